// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer
// Brief  : Instruction fetch, phase sequencing and PC update for a multi-cycle
//          execution of the single-cycle MIPS datapath.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned STALL_CYCLES = 5,
  parameter logic [31:0] RESET_PC     = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_data,
  input  logic [15:0] imm16,
  input  logic        npc_sel,
  input  logic        hold,
  output logic [31:0] imem_adr,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        wr_strobe,
  output logic        commit,
  output logic [31:0] retired
);

  localparam logic [3:0] c_PH_FETCH = 4'd0;
  localparam logic [3:0] c_PH_WRITE = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] c_PH_LAST  = 4'(STALL_CYCLES);

  logic [3:0]  r_phase;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retired;

  logic        w_advance;
  logic [31:0] w_branch_off;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_next;

  // r_run stays low for the first edge after reset so that phase 0 begins cleanly.
  assign w_advance    = r_run & ~hold;
  assign w_branch_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign w_pc_seq     = r_pc + 32'd4;
  assign w_pc_next    = npc_sel ? (w_pc_seq + w_branch_off) : w_pc_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= c_PH_FETCH;
      r_run     <= 1'b0;
      r_pc      <= RESET_PC;
      r_inst    <= 32'h0000_0000;
      r_retired <= 32'h0000_0000;
    end else begin
      r_run <= 1'b1;
      if (w_advance) begin
        if (r_phase == c_PH_FETCH) begin
          r_inst <= imem_data;
        end
        if (r_phase == c_PH_LAST) begin
          r_phase   <= c_PH_FETCH;
          r_pc      <= w_pc_next;
          r_retired <= r_retired + 32'd1;
        end else begin
          r_phase <= r_phase + 4'd1;
        end
      end
    end
  end

  assign imem_adr   = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign retired    = r_retired;
  assign inst_valid = (r_phase != c_PH_FETCH);
  assign wr_strobe  = w_advance & (r_phase == c_PH_WRITE);
  assign commit     = w_advance & (r_phase == c_PH_LAST);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : Scoreboard bench for fetch_sequencer against an instruction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int          N    = 5;
  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ret;
    logic        valid;
    logic        wr;
    logic        com;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_data;
  logic [15:0] imm16 = '0;
  logic        npc_sel = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] imem_adr, pc, inst, retired;
  logic        inst_valid, wr_strobe, commit;

  logic        rst2_n = 1'b0;
  logic [31:0] imem_data2;
  logic [15:0] imm2 = '0;
  logic        ns2 = 1'b0;
  logic        hold2 = 1'b0;
  logic [31:0] imem_adr2, pc2, inst2, retired2;
  logic        valid2, wr2, com2;

  int tests = 0;
  int fails = 0;

  cyc_t cyc_q[$];
  cyc_t e;
  bit   mon_en = 1'b0;

  // Instruction-level reference state
  logic [31:0] m_pc, m_inst, m_ret;
  int          m_pos;
  bit          m_started;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data  = mem_word(imem_adr);
  assign imem_data2 = mem_word(imem_adr2);

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_data(imem_data), .imm16(imm16),
    .npc_sel(npc_sel), .hold(hold), .imem_adr(imem_adr), .pc(pc),
    .inst(inst), .inst_valid(inst_valid), .wr_strobe(wr_strobe),
    .commit(commit), .retired(retired)
  );

  fetch_sequencer #(.STALL_CYCLES(2), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_data(imem_data2), .imm16(imm2),
    .npc_sel(ns2), .hold(hold2), .imem_adr(imem_adr2), .pc(pc2),
    .inst(inst2), .inst_valid(valid2), .wr_strobe(wr2),
    .commit(com2), .retired(retired2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got empty queue expected a cycle record");
      end else begin
        e = cyc_q.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_adr", imem_adr, e.pc);
        chk("inst", inst, e.inst);
        chk("retired", retired, e.ret);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, e.valid});
        chk("wr_strobe", {31'd0, wr_strobe}, {31'd0, e.wr});
        chk("commit", {31'd0, commit}, {31'd0, e.com});
      end
    end
  end

  // Drives one cycle (called just after a rising edge) and queues its expectation.
  task automatic step(input bit h, input bit ns, input logic [15:0] im);
    cyc_t r;
    int   off;
    hold    = h;
    npc_sel = ns;
    imm16   = im;
    r.pc    = m_pc;
    r.inst  = m_inst;
    r.ret   = m_ret;
    r.valid = m_started && (m_pos != 0);
    r.wr    = m_started && !h && (m_pos == N - 1);
    r.com   = m_started && !h && (m_pos == N);
    cyc_q.push_back(r);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!h) begin
      if (m_pos == 0) m_inst = mem_word(m_pc);
      if (m_pos == N) begin
        off   = ns ? int'($signed(im)) * 4 : 0;
        m_pc  = m_pc + 32'd4 + 32'(off);
        m_ret = m_ret + 32'd1;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input bit ns_commit, input logic [15:0] im, input bit ns_ph2);
    for (int i = 0; i <= N; i++) begin
      step(1'b0, (i == N) ? ns_commit : ((i == 2) ? ns_ph2 : 1'b0), im);
    end
  endtask

  task automatic do_reset(input int cycles);
    mon_en  = 1'b0;
    rst_n   = 1'b0;
    hold    = 1'b0;
    npc_sel = 1'b0;
    imm16   = '0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("rst_pc", pc, RPC);
      chk("rst_inst", inst, 32'h0);
      chk("rst_retired", retired, 32'h0);
      chk("rst_flags", {29'd0, inst_valid, wr_strobe, commit}, 32'h0);
    end
    cyc_q.delete();
    m_pc      = RPC;
    m_inst    = 32'h0;
    m_ret     = 32'h0;
    m_pos     = 0;
    m_started = 1'b0;
    rst_n     = 1'b1;
    mon_en    = 1'b1;
    step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_dut2(input bit ns, input logic [15:0] im, input logic [31:0] exp_pc);
    int nwr;
    int ncom;
    nwr    = 0;
    ncom   = 0;
    rst2_n = 1'b0;
    ns2    = ns;
    imm2   = im;
    @(posedge clk);
    #1;
    chk("d2_rst_pc", pc2, RPC2);
    rst2_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nwr  += int'(wr2);
      ncom += int'(com2);
      @(posedge clk);
      #1;
    end
    chk("d2_wr_count", 32'(nwr), 32'd1);
    chk("d2_commit_count", 32'(ncom), 32'd1);
    chk("d2_pc_wrap", pc2, exp_pc);
    chk("d2_retired", retired2, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    for (int i = 0; i < 3; i++) run_instr(1'b0, 16'h0, 1'b0);
    chk("seq_pc", pc, 32'h0040_000C);
    chk("seq_retired", retired, 32'd3);

    run_instr(1'b0, 16'h0, 1'b0);
    chk("pre_branch_pc", pc, 32'h0040_0010);
    run_instr(1'b1, 16'h0003, 1'b0);
    chk("branch_fwd", pc, 32'h0040_0020);
    run_instr(1'b1, 16'hFFFB, 1'b0);
    chk("branch_back", pc, 32'h0040_0010);
    run_instr(1'b1, 16'hFFFF, 1'b0);
    chk("branch_self", pc, 32'h0040_0010);
    run_instr(1'b0, 16'h1234, 1'b1);
    chk("npc_sel_ph2_ignored", pc, 32'h0040_0014);

    for (int i = 0; i < N - 1; i++) step(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0100);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    chk("hold_pc", pc, 32'h0040_0018);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    do_reset(2);
    run_instr(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, RPC);
    chk("async_inst", inst, 32'h0);
    chk("async_retired", retired, 32'h0);
    chk("async_flags", {29'd0, inst_valid, wr_strobe, commit}, 32'h0);
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(1'b0, 16'h0, 1'b0);
    chk("refetch_pc", pc, RPC + 32'd4);
    chk("refetch_retired", retired, 32'd1);
    mon_en = 1'b0;
    chk("sb_drained", 32'(cyc_q.size()), 32'd0);

    run_dut2(1'b0, 16'h0, 32'h0000_0000);
    run_dut2(1'b1, 16'h0001, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
